// File: rtl/ccc_seq_pkg.sv
// Shared definitions for the CCC lock / reset sequencer: state encoding,
// and a helper for sizing the shared cycle counter.
package ccc_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_FILTER    = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_HOLD      = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ccc_lock_sync.sv
// Two-flop synchroniser for one asynchronous lock indicator.
module ccc_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second gives a clean level two edges later.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ccc_lock_reset_sequencer.sv
// Watches CCC lock, filters it, and releases the staged fabric resets in
// ascending order. Any lock loss after release re-asserts everything at once.
module ccc_lock_reset_sequencer
    import ccc_seq_pkg::*;
#(
    parameter int NUM_STAGES   = 3,
    parameter int LOCK_FILTER  = 1024,
    parameter int STAGE_GAP    = 256,
    parameter int LOCK_TIMEOUT = 100000,
    parameter bit USE_MSS_LOCK = 1'b1,
    parameter int LOSS_W       = 8
) (
    input  logic                  FAB_CLK,
    input  logic                  RESET,
    input  logic                  FAB_LOCK,
    input  logic                  MSS_LOCK,
    input  logic                  RETRY,
    output logic [NUM_STAGES-1:0] STAGE_RST,
    output logic                  READY,
    output logic                  FAULT,
    output logic [LOSS_W-1:0]     LOSS_COUNT,
    output logic [2:0]            STATE
);

    localparam int CNT_MAX = max3(LOCK_FILTER, STAGE_GAP * NUM_STAGES, LOCK_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FLT_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] REL_END   = CNT_W'(STAGE_GAP * NUM_STAGES);
    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(STAGE_GAP);

    logic fab_s, mss_s, lock_q;

    ccc_lock_sync u_sync_fab (.clk(FAB_CLK), .rst(RESET), .d(FAB_LOCK), .q(fab_s));
    ccc_lock_sync u_sync_mss (.clk(FAB_CLK), .rst(RESET), .d(MSS_LOCK), .q(mss_s));

    assign lock_q = fab_s & ((USE_MSS_LOCK != 1'b0) ? mss_s : 1'b1);

    seq_state_t             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt, cnt_inc;
    logic [NUM_STAGES-1:0]  stage_rst_nxt;
    logic                   ready_nxt, fault_nxt;
    logic [LOSS_W-1:0]      loss_nxt;

    assign cnt_inc = cnt + 1'b1;

    // State and shared counter register.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; the counter restarts from zero on every transition.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_WAIT_LOCK: begin
                if (lock_q) begin
                    state_nxt = ST_FILTER;
                    cnt_nxt   = '0;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = ST_FAULT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end
            ST_FILTER: begin
                if (!lock_q) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == FLT_LAST) begin
                    state_nxt = ST_RELEASE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end
            ST_RELEASE: begin
                if (!lock_q) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else if (cnt_inc == REL_END) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end
            ST_RUN: begin
                if (!lock_q) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end
            end
            ST_HOLD: begin
                // Lock is deliberately ignored here so a bouncing CCC gets a quiet period.
                if (cnt_inc == HOLD_END) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end
            ST_FAULT: begin
                if (RETRY) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Next output values, derived from where the FSM is heading this edge.
    always_comb begin
        stage_rst_nxt = '1;
        ready_nxt     = 1'b0;
        fault_nxt     = (state_nxt == ST_FAULT);
        loss_nxt      = LOSS_COUNT;
        case (state_nxt)
            ST_RELEASE: begin
                if (state != ST_RELEASE) begin
                    stage_rst_nxt    = '1;
                    stage_rst_nxt[0] = 1'b0;
                end else begin
                    stage_rst_nxt = STAGE_RST;
                    for (int k = 1; k < NUM_STAGES; k++) begin
                        if (cnt_inc == CNT_W'(k * STAGE_GAP))
                            stage_rst_nxt[k] = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                stage_rst_nxt = '0;
                ready_nxt     = 1'b1;
            end
            default: begin
                stage_rst_nxt = '1;
            end
        endcase
        if (state_nxt == ST_HOLD && state != ST_HOLD && !(&LOSS_COUNT))
            loss_nxt = LOSS_COUNT + 1'b1;
    end

    // Output registers.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            STAGE_RST  <= '1;
            READY      <= 1'b0;
            FAULT      <= 1'b0;
            LOSS_COUNT <= '0;
        end else begin
            STAGE_RST  <= stage_rst_nxt;
            READY      <= ready_nxt;
            FAULT      <= fault_nxt;
            LOSS_COUNT <= loss_nxt;
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_ccc_lock_reset_sequencer.sv
// Directed bench: bring-up timing, filter glitch, lock loss and counter
// saturation, mid-release reset, timeout/retry.
module tb_ccc_lock_reset_sequencer;

    logic       FAB_CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       FAB_LOCK = 1'b0;
    logic       MSS_LOCK = 1'b0;
    logic       RETRY = 1'b0;
    logic [2:0] STAGE_RST;
    logic       READY;
    logic       FAULT;
    logic [1:0] LOSS_COUNT;
    logic [2:0] STATE;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    ccc_lock_reset_sequencer #(
        .NUM_STAGES(3), .LOCK_FILTER(8), .STAGE_GAP(4),
        .LOCK_TIMEOUT(50), .USE_MSS_LOCK(1'b1), .LOSS_W(2)
    ) dut (
        .FAB_CLK(FAB_CLK), .RESET(RESET), .FAB_LOCK(FAB_LOCK), .MSS_LOCK(MSS_LOCK),
        .RETRY(RETRY), .STAGE_RST(STAGE_RST), .READY(READY), .FAULT(FAULT),
        .LOSS_COUNT(LOSS_COUNT), .STATE(STATE)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge FAB_CLK);
        #1;
        cyc++;
    endtask

    task automatic to(input int n);
        while (cyc < n) step();
    endtask

    // The reset edge is cycle 0; RESET drops right after it.
    task automatic do_reset(input logic lk);
        RESET = 1'b1;
        FAB_LOCK = lk;
        MSS_LOCK = lk;
        RETRY = 1'b0;
        @(posedge FAB_CLK);
        #1;
        cyc = 0;
        RESET = 1'b0;
    endtask

    initial begin
        // ---- clean bring-up ----
        do_reset(1'b1);
        chk("rst_stage", 32'(STAGE_RST), 32'h7);
        chk("rst_ready", 32'(READY), 32'h0);
        chk("rst_fault", 32'(FAULT), 32'h0);
        chk("rst_loss", 32'(LOSS_COUNT), 32'h0);
        chk("rst_state", 32'(STATE), 32'h0);
        to(3);  chk("up_filter", 32'(STATE), 32'h1);
        to(10); chk("up_stage10", 32'(STAGE_RST), 32'h7);
        to(11); chk("up_stage11", 32'(STAGE_RST), 32'h6);
                chk("up_release", 32'(STATE), 32'h2);
        to(14); chk("up_stage14", 32'(STAGE_RST), 32'h6);
        to(15); chk("up_stage15", 32'(STAGE_RST), 32'h4);
        to(18); chk("up_stage18", 32'(STAGE_RST), 32'h4);
        to(19); chk("up_stage19", 32'(STAGE_RST), 32'h0);
        to(22); chk("up_ready22", 32'(READY), 32'h0);
        to(23); chk("up_ready23", 32'(READY), 32'h1);
                chk("up_run", 32'(STATE), 32'h3);
                chk("up_loss", 32'(LOSS_COUNT), 32'h0);

        // ---- lock loss in RUN at cycle 30 ----
        to(30); FAB_LOCK = 1'b0;
        to(32); chk("loss_stage32", 32'(STAGE_RST), 32'h0);
                chk("loss_ready32", 32'(READY), 32'h1);
        to(33); chk("loss_stage33", 32'(STAGE_RST), 32'h7);
                chk("loss_ready33", 32'(READY), 32'h0);
                chk("loss_hold", 32'(STATE), 32'h4);
                chk("loss_cnt1", 32'(LOSS_COUNT), 32'h1);
        to(34); FAB_LOCK = 1'b1;
        to(36); chk("hold36", 32'(STATE), 32'h4);
        to(37); chk("hold_exit37", 32'(STATE), 32'h0);
        to(38); chk("rebring_filter", 32'(STATE), 32'h1);
        to(46); chk("rebring_rel", 32'(STATE), 32'h2);
                chk("rebring_stage", 32'(STAGE_RST), 32'h6);
        to(57); chk("rebring_ready57", 32'(READY), 32'h0);
        to(58); chk("rebring_ready58", 32'(READY), 32'h1);

        // ---- four more losses: 2-bit counter saturates at 3 ----
        for (int i = 0; i < 4; i++) begin
            int exp_loss;
            int budget;
            exp_loss = (i == 0) ? 2 : 3;
            if (i % 2 == 0) MSS_LOCK = 1'b0; else FAB_LOCK = 1'b0;
            step(); step(); step();
            chk("sat_loss", 32'(LOSS_COUNT), 32'(exp_loss));
            chk("sat_stage", 32'(STAGE_RST), 32'h7);
            FAB_LOCK = 1'b1;
            MSS_LOCK = 1'b1;
            budget = 0;
            while (!READY && budget < 100) begin
                step();
                budget++;
            end
            chk("sat_ready_back", 32'(READY), 32'h1);
        end

        // ---- one-cycle FAB_LOCK glitch during FILTER ----
        do_reset(1'b1);
        to(6);  FAB_LOCK = 1'b0;
        to(7);  FAB_LOCK = 1'b1;
        to(8);  chk("gl_filter8", 32'(STATE), 32'h1);
        to(9);  chk("gl_wait9", 32'(STATE), 32'h0);
                chk("gl_loss9", 32'(LOSS_COUNT), 32'h0);
        to(10); chk("gl_filter10", 32'(STATE), 32'h1);
        to(17); chk("gl_stage17", 32'(STAGE_RST), 32'h7);
        to(18); chk("gl_stage18", 32'(STAGE_RST), 32'h6);
        to(22); chk("gl_stage22", 32'(STAGE_RST), 32'h4);
        to(26); chk("gl_stage26", 32'(STAGE_RST), 32'h0);
        to(29); chk("gl_ready29", 32'(READY), 32'h0);
        to(30); chk("gl_ready30", 32'(READY), 32'h1);
                chk("gl_loss30", 32'(LOSS_COUNT), 32'h0);

        // ---- RESET in the middle of RELEASE ----
        do_reset(1'b1);
        to(12); chk("mr_stage12", 32'(STAGE_RST), 32'h6);
        RESET = 1'b1;
        to(13); chk("mr_stage", 32'(STAGE_RST), 32'h7);
                chk("mr_ready", 32'(READY), 32'h0);
                chk("mr_fault", 32'(FAULT), 32'h0);
                chk("mr_state", 32'(STATE), 32'h0);
        RESET = 1'b0;
        to(23); chk("mr_stage23", 32'(STAGE_RST), 32'h7);
        to(24); chk("mr_stage24", 32'(STAGE_RST), 32'h6);

        // ---- lock timeout, retry, re-timeout ----
        do_reset(1'b0);
        to(49); chk("to_fault49", 32'(FAULT), 32'h0);
                chk("to_state49", 32'(STATE), 32'h0);
        to(50); chk("to_fault50", 32'(FAULT), 32'h1);
                chk("to_state50", 32'(STATE), 32'h5);
                chk("to_stage50", 32'(STAGE_RST), 32'h7);
        to(55); RETRY = 1'b1;
        to(56); RETRY = 1'b0;
                chk("rt_fault", 32'(FAULT), 32'h0);
                chk("rt_state", 32'(STATE), 32'h0);
        // RETRY outside FAULT must not restart the timer
        to(60); RETRY = 1'b1;
        to(61); RETRY = 1'b0;
        to(105); chk("rt_fault105", 32'(FAULT), 32'h0);
        to(106); chk("rt_fault106", 32'(FAULT), 32'h1);
                 chk("rt_state106", 32'(STATE), 32'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
